// File: rtl/flash_boot_ctrl_if.sv
// flash_boot_ctrl_if: SPI flash pins and Wishbone master signals of the boot
// sequencer, bundled so the controller and its surroundings share one port.
interface flash_boot_ctrl_if;
    logic        o_flash_sclk;
    logic        o_flash_cs_n;
    logic        o_flash_mosi;
    logic        i_flash_miso;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack;

    modport master (
        output o_flash_sclk, o_flash_cs_n, o_flash_mosi,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
        input  i_flash_miso, i_wb_ack
    );

    modport slave (
        input  o_flash_sclk, o_flash_cs_n, o_flash_mosi,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
        output i_flash_miso, i_wb_ack
    );
endinterface

// File: rtl/flash_boot_ctrl.sv
// flash_boot_ctrl: after reset, holds the core in reset, streams BOOT_WORDS
// words out of SPI flash (READ 0x03, mode 0) and writes them into instruction
// memory over Wishbone, then releases the core.
// Optional feature macro: BOOT_CHECKSUM_EN -- one extra flash word is read
// after the image and compared against the mod-2^32 sum of the image words.
module flash_boot_ctrl #(
    parameter int unsigned BOOT_WORDS = 1024,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [31:0] IMEM_BASE  = 32'h00000000,
    parameter int unsigned SCLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              reset,
    flash_boot_ctrl_if.master bus,
    output logic              o_core_reset_n,
    output logic              o_boot_done,
    output logic              o_boot_err
);
    localparam int CNT_W = $clog2(BOOT_WORDS + 1);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_WORDS - 1);
    localparam logic [31:0]      CMD_WORD = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      shreg;
    logic [CNT_W-1:0] word_cnt;
    logic             spi_tick, sclk_rise, sclk_fall, last_bit, last_word;
    logic [31:0]      rx_word;

`ifdef BOOT_CHECKSUM_EN
    logic             chk_phase;
    logic [31:0]      sum;
    logic             err_q;
    assign o_boot_err = err_q;
`else
    assign o_boot_err = 1'b0;
`endif

    // Next-state logic plus SPI edge strobes; sclk toggles when the divider wraps.
    always_comb begin
        spi_tick  = ((state == S_CMD) || (state == S_READ)) && (div_cnt == DIV_LAST);
        sclk_rise = spi_tick && !bus.o_flash_sclk;
        sclk_fall = spi_tick && bus.o_flash_sclk;
        last_bit  = (bit_cnt == 5'd31);
        last_word = (word_cnt == CNT_LAST);
        // first byte received sits in shreg[31:24]; it belongs in bits 7:0
        rx_word   = {shreg[7:0], shreg[15:8], shreg[23:16], shreg[31:24]};
        state_d   = state;
        case (state)
            S_IDLE:  state_d = S_CMD;
            S_CMD:   if (sclk_fall && last_bit) state_d = S_READ;
            S_READ: begin
                if (sclk_fall && last_bit) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = chk_phase ? S_DONE : S_WRITE;
`else
                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                if (bus.i_wb_ack) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_READ;
`else
                    state_d = last_word ? S_DONE : S_READ;
`endif
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // SPI shifter, Wishbone master and boot status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.o_flash_sclk <= 1'b0;
            bus.o_flash_cs_n <= 1'b1;
            bus.o_flash_mosi <= 1'b0;
            bus.o_wb_adr     <= '0;
            bus.o_wb_dat     <= '0;
            bus.o_wb_sel     <= '0;
            bus.o_wb_we      <= 1'b0;
            bus.o_wb_cyc     <= 1'b0;
            bus.o_wb_stb     <= 1'b0;
            o_core_reset_n   <= 1'b0;
            o_boot_done      <= 1'b0;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            shreg            <= '0;
            word_cnt         <= '0;
`ifdef BOOT_CHECKSUM_EN
            chk_phase        <= 1'b0;
            sum              <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // select the flash and present the first command bit
                    bus.o_flash_cs_n <= 1'b0;
                    bus.o_flash_sclk <= 1'b0;
                    bus.o_flash_mosi <= CMD_WORD[31];
                    shreg            <= CMD_WORD;
                    div_cnt          <= '0;
                    bit_cnt          <= '0;
                end
                S_CMD, S_READ: begin
                    if (spi_tick) begin
                        div_cnt          <= '0;
                        bus.o_flash_sclk <= ~bus.o_flash_sclk;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (sclk_rise && state == S_READ)
                        shreg <= {shreg[30:0], bus.i_flash_miso};
                    if (sclk_fall) begin
                        bit_cnt <= bit_cnt + 5'd1;  // wraps to 0 after bit 31
                        if (state == S_CMD) begin
                            if (last_bit) begin
                                bus.o_flash_mosi <= 1'b0;
                            end else begin
                                bus.o_flash_mosi <= shreg[30];
                                shreg            <= {shreg[30:0], 1'b0};
                            end
                        end else if (last_bit) begin
`ifdef BOOT_CHECKSUM_EN
                            if (chk_phase) begin
                                bus.o_flash_cs_n <= 1'b1;
                                o_boot_done      <= 1'b1;
                                o_core_reset_n   <= (rx_word == sum);
                                err_q            <= (rx_word != sum);
                            end else begin
`else
                            begin
`endif
                                bus.o_wb_cyc <= 1'b1;
                                bus.o_wb_stb <= 1'b1;
                                bus.o_wb_we  <= 1'b1;
                                bus.o_wb_sel <= 4'hF;
                                bus.o_wb_adr <= IMEM_BASE + (32'(word_cnt) << 2);
                                bus.o_wb_dat <= rx_word;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    // sclk stays low here, which pauses the continuous read
                    if (bus.i_wb_ack) begin
                        bus.o_wb_cyc <= 1'b0;
                        bus.o_wb_stb <= 1'b0;
                        bus.o_wb_we  <= 1'b0;
                        bus.o_wb_sel <= 4'h0;
                        word_cnt     <= word_cnt + CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        sum <= sum + bus.o_wb_dat;
                        if (last_word) chk_phase <= 1'b1;
`else
                        if (last_word) begin
                            bus.o_flash_cs_n <= 1'b1;
                            o_boot_done      <= 1'b1;
                            o_core_reset_n   <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_boot_ctrl.sv
// tb_flash_boot_ctrl: flash and Wishbone slave models around flash_boot_ctrl,
// with an image-level reference model for the expected writes.
module tb_flash_boot_ctrl;
    localparam int          NW    = 4;
    localparam logic [23:0] FBASE = 24'h000000;
    localparam logic [31:0] IBASE = 32'h00000000;
`ifdef BOOT_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int EXP_RISES = 32 + 32 * (NW + CHK);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic core_rst_n, done, err;
    flash_boot_ctrl_if m();

    flash_boot_ctrl #(.BOOT_WORDS(NW), .FLASH_BASE(FBASE), .IMEM_BASE(IBASE), .SCLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .bus(m),
        .o_core_reset_n(core_rst_n), .o_boot_done(done), .o_boot_err(err)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] fmem [0:31];
    int         dly [0:NW-1];
    bit         spur_en;

    int          cyc_cnt = 0, rises, mosi_bad, pause_bad, wb_bad, early_rel;
    int          ack_cyc, done_cyc, hold, wcnt;
    logic [31:0] cmd_bits, cur_adr, cur_dat;
    logic        sclk_p, csn_p, mosi_p;
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          wr_hold[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input int k);
        int a;
        a = k >> 3;
        if (a > 31) return 1'b0;
        return fmem[a][7 - (k & 7)];
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        return {fmem[4*i+3], fmem[4*i+2], fmem[4*i+1], fmem[4*i]};
    endfunction

    task automatic set_word(input int i, input logic [31:0] w);
        fmem[4*i]   = w[7:0];
        fmem[4*i+1] = w[15:8];
        fmem[4*i+2] = w[23:16];
        fmem[4*i+3] = w[31:24];
    endtask

    task automatic set_sum(input logic [31:0] adj);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < NW; i++) s = s + exp_word(i);
        set_word(NW, s + adj);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run();
        reset = 1'b1;
        tick(); tick();
        wr_adr.delete(); wr_dat.delete(); wr_hold.delete();
        rises = 0; mosi_bad = 0; pause_bad = 0; wb_bad = 0; early_rel = 0;
        ack_cyc = -1; done_cyc = -1; hold = 0; cmd_bits = 32'h0;
        reset = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit exp_err);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin tick(); n++; end
        chk({tag, " done"}, {31'h0, done}, 32'h1);
        repeat (10) tick();
        chk({tag, " nwrites"}, wr_adr.size(), NW);
        for (int i = 0; i < NW && i < wr_adr.size(); i++) begin
            chk($sformatf("%s adr%0d", tag, i), wr_adr[i], IBASE + 32'(4 * i));
            chk($sformatf("%s dat%0d", tag, i), wr_dat[i], exp_word(i));
        end
        chk({tag, " cmd"}, cmd_bits, {8'h03, FBASE});
        chk({tag, " sclk_rises"}, rises, EXP_RISES);
        chk({tag, " mosi_bad"}, mosi_bad, 0);
        chk({tag, " sclk_in_write"}, pause_bad, 0);
        chk({tag, " wb_unstable"}, wb_bad, 0);
        chk({tag, " early_release"}, early_rel, 0);
        chk({tag, " cs_n"}, {31'h0, m.o_flash_cs_n}, 32'h1);
        chk({tag, " done_err_rstn"}, {29'h0, done, err, core_rst_n}, {29'h0, 1'b1, exp_err, !exp_err});
`ifndef BOOT_CHECKSUM_EN
        chk({tag, " done_latency"}, done_cyc, ack_cyc + 1);
`endif
    endtask

    // Flash device, Wishbone slave and bus monitor, all sampled on the falling clk edge.
    initial begin
        m.i_flash_miso = 1'b0; m.i_wb_ack = 1'b0;
        sclk_p = 1'b0; csn_p = 1'b1; mosi_p = 1'b0; wcnt = 0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (m.o_wb_cyc === 1'b1 && m.i_wb_ack !== 1'b1) begin
                wcnt++;
                if (wcnt > ((wr_adr.size() < NW) ? dly[wr_adr.size()] : 0)) m.i_wb_ack = 1'b1;
            end else begin
                wcnt = 0;
                m.i_wb_ack = spur_en && (m.o_wb_cyc !== 1'b1) && ($urandom_range(0, 3) == 0);
            end
            if (m.o_flash_cs_n === 1'b0) begin
                if (csn_p) begin rises = 0; cmd_bits = 32'h0; end
                if (m.o_flash_sclk && !sclk_p) begin
                    if (m.o_flash_mosi !== mosi_p) mosi_bad++;
                    if (rises < 32) cmd_bits = {cmd_bits[30:0], m.o_flash_mosi};
                    else if (m.o_flash_mosi !== 1'b0) mosi_bad++;
                    rises++;
                end
                if (!m.o_flash_sclk && sclk_p && rises >= 32) m.i_flash_miso = fbit(rises - 32);
            end else begin
                m.i_flash_miso = 1'b0;
            end
            if (m.o_wb_cyc === 1'b1) begin
                if (m.o_flash_sclk !== 1'b0) pause_bad++;
                if (hold == 0) begin cur_adr = m.o_wb_adr; cur_dat = m.o_wb_dat; end
                else if (m.o_wb_adr !== cur_adr || m.o_wb_dat !== cur_dat) wb_bad++;
                if (m.o_wb_sel !== 4'hF || m.o_wb_we !== 1'b1 || m.o_wb_stb !== 1'b1) wb_bad++;
                hold++;
                if (m.i_wb_ack === 1'b1) begin
                    wr_adr.push_back(m.o_wb_adr);
                    wr_dat.push_back(m.o_wb_dat);
                    wr_hold.push_back(hold);
                    ack_cyc = cyc_cnt;
                    hold = 0;
                end
            end
            if (core_rst_n === 1'b1 && done !== 1'b1) early_rel++;
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc_cnt;
            sclk_p = m.o_flash_sclk; csn_p = m.o_flash_cs_n; mosi_p = m.o_flash_mosi;
        end
    end

    // Two small instances measure the sclk period for SCLK_DIV 1 and 4.
    for (genvar g = 0; g < 2; g++) begin : g_div
        localparam int DIV = (g == 0) ? 1 : 4;
        flash_boot_ctrl_if b();
        logic crn, dn, er;
        int   per, mbad, ccnt, last;
        logic sp, mp;
        flash_boot_ctrl #(.BOOT_WORDS(1), .SCLK_DIV(DIV)) u (
            .clk(clk), .reset(reset), .bus(b),
            .o_core_reset_n(crn), .o_boot_done(dn), .o_boot_err(er)
        );
        initial begin
            b.i_flash_miso = 1'b0; b.i_wb_ack = 1'b1;
            per = 0; mbad = 0; ccnt = 0; last = -1; sp = 1'b0; mp = 1'b0;
            forever begin
                @(negedge clk);
                ccnt++;
                if (b.o_flash_sclk === 1'b1 && sp === 1'b0) begin
                    if (b.o_flash_mosi !== mp) mbad++;
                    if (last >= 0 && per == 0) per = ccnt - last;
                    last = ccnt;
                end
                sp = b.o_flash_sclk; mp = b.o_flash_mosi;
            end
        end
    end

    initial begin
        int n;
        spur_en = 1'b0;
        for (int i = 0; i < NW; i++) dly[i] = 0;
        for (int i = 0; i < 32; i++) fmem[i] = 8'h00;

        // reset values
        tick(); tick();
        chk("rst_spi", {29'h0, m.o_flash_sclk, m.o_flash_cs_n, m.o_flash_mosi}, 32'h2);
        chk("rst_wb_ctl", {24'h0, m.o_wb_cyc, m.o_wb_stb, m.o_wb_we, 1'b0, m.o_wb_sel}, 32'h0);
        chk("rst_wb_adr", m.o_wb_adr, 32'h0);
        chk("rst_wb_dat", m.o_wb_dat, 32'h0);
        chk("rst_status", {29'h0, core_rst_n, done, err}, 32'h0);

        // directed image from the boot ROM example
        set_word(0, 32'h00000013); set_word(1, 32'h00100093);
        set_word(2, 32'h00200113); set_word(3, 32'h00308193);
        set_sum(32'h0);
        start_run();
        tick();
        chk("idle_one_cycle cs_n", {31'h0, m.o_flash_cs_n}, 32'h0);
        chk("cmd_first_bit", {30'h0, m.o_flash_sclk, m.o_flash_mosi}, 32'h0);
        run_check("directed", 1'b0);

        // little-endian assembly plus a 5-cycle ack delay on word 1
        for (int i = 0; i < NW; i++) begin set_word(i, $urandom); dly[i] = $urandom_range(0, 3); end
        set_word(0, 32'h12345678);
        dly[1] = 5;
        set_sum(32'h0);
        start_run();
        run_check("ack_delay", 1'b0);
        chk("endian word0", wr_dat[0], 32'h12345678);
        chk("ack_delay hold", wr_hold[1], 6);

        // random image, random ack latency, spurious acks while cyc=0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NW; i++) begin set_word(i, $urandom); dly[i] = $urandom_range(0, 4); end
            set_sum(32'h0);
            spur_en = 1'b1;
            start_run();
            run_check($sformatf("random%0d", r), 1'b0);
            spur_en = 1'b0;
        end

        // reset pulsed while reading word 2
        for (int i = 0; i < NW; i++) begin set_word(i, $urandom); dly[i] = 0; end
        set_sum(32'h0);
        start_run();
        n = 0;
        while (wr_adr.size() < 2 && n < 5000) begin tick(); n++; end
        chk("midreset reached word2", wr_adr.size(), 2);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        chk("midreset spi", {30'h0, m.o_flash_cs_n, m.o_flash_sclk}, 32'h2);
        chk("midreset status", {29'h0, m.o_wb_cyc, core_rst_n, done}, 32'h0);
        start_run();
        run_check("after_reset", 1'b0);

        // checksum words 1,2,3,4 with a good then a bad trailer
        for (int i = 0; i < NW; i++) set_word(i, 32'(i + 1));
        set_word(NW, 32'h0000000A);
        start_run();
        run_check("chk_good", 1'b0);
        set_word(NW, 32'h0000000B);
        start_run();
        run_check("chk_bad", CHK != 0);

        repeat (400) tick();
        chk("div1 period", g_div[0].per, 2);
        chk("div4 period", g_div[1].per, 8);
        chk("div1 mosi_at_rise", g_div[0].mbad, 0);
        chk("div4 mosi_at_rise", g_div[1].mbad, 0);
        chk("div_done", {30'h0, g_div[0].dn, g_div[1].dn}, 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
